// File: rtl/video_scanout.sv
// video_scanout: VGA-style raster timing generator and framebuffer scan-out.
// Each visible pixel is fetched from video memory as one 32-bit word and
// replicated SCALE times horizontally and SCALE lines vertically. The
// counter position reaches the registered outputs after two pix_ce ticks.
module video_scanout #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          SCALE     = 4,
    parameter int          FB_WIDTH  = 160,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        enable,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int XW      = $clog2(FB_WIDTH + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
    localparam logic [31:0]   ROW_STEP = 32'(FB_WIDTH * 4);

    // stage 0: raster position and framebuffer walk
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [SW-1:0] h_sub;
    logic [SW-1:0] v_sub;
    logic [XW-1:0] fb_x;
    logic [31:0]   row_base;

    // stage 1: decoded position, aligned with the outgoing read
    logic          de_s1;
    logic          hs_act_s1;
    logic          vs_act_s1;
    logic          en_s1;
    logic          first_s1;

    // data capture for the read issued at stage 1
    logic [11:0]   data_q;

    // combinational decode of the current counter position
    logic          vis;
    logic          hs_act;
    logic          vs_act;
    logic          first_pix;
    logic [31:0]   pix_addr;
    logic [11:0]   pix_data;
    logic          rd_data_unused;

    // decode of the stage-0 position and selection of the returning pixel
    always_comb begin
        vis       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_act    = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_act    = (v_cnt >= VS_START) && (v_cnt < VS_END);
        first_pix = (h_cnt == '0) && (v_cnt == '0);
        pix_addr  = BASE_ADDR + row_base + {{(30 - XW){1'b0}}, fb_x, 2'b00};
        // With back-to-back ticks the word arrives in the same clk the
        // output stage needs it; otherwise it was parked in data_q.
        pix_data  = rd_en ? rd_data[11:0] : data_q;
    end

    // only RGB444 is used from each word
    assign rd_data_unused = ^rd_data[31:12];

    // raster counters plus the divider-free framebuffer address walk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            h_sub    <= '0;
            v_sub    <= '0;
            fb_x     <= '0;
            row_base <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                h_sub <= '0;
                fb_x  <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt    <= '0;
                    v_sub    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                    // rows only advance across visible lines
                    if (v_cnt < V_ACT) begin
                        if (v_sub == S_LAST) begin
                            v_sub    <= '0;
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            v_sub <= v_sub + SW'(1);
                        end
                    end
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
                if (h_cnt < H_ACT) begin
                    if (h_sub == S_LAST) begin
                        h_sub <= '0;
                        fb_x  <= fb_x + XW'(1);
                    end else begin
                        h_sub <= h_sub + SW'(1);
                    end
                end
            end
        end
    end

    // stage 1: issue the memory read and carry the decoded timing along
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            de_s1     <= 1'b0;
            hs_act_s1 <= 1'b0;
            vs_act_s1 <= 1'b0;
            en_s1     <= 1'b0;
            first_s1  <= 1'b0;
        end else begin
            // strobe lasts one clk per pixel even when pix_ce is sparse
            rd_en <= pix_ce && vis && enable;
            if (pix_ce) begin
                if (vis && enable) begin
                    rd_addr <= pix_addr;
                end
                de_s1     <= vis;
                hs_act_s1 <= hs_act;
                vs_act_s1 <= vs_act;
                en_s1     <= enable;
                first_s1  <= first_pix;
            end
        end
    end

    // capture read data one clk after the strobe; runs independent of pix_ce
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= rd_data[11:0];
        end
    end

    // stage 2: registered display outputs, all aligned to one pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && first_s1;
            if (pix_ce) begin
                hsync <= ~hs_act_s1;
                vsync <= ~vs_act_s1;
                de    <= de_s1;
                rgb   <= (de_s1 && en_s1) ? pix_data : 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_video_scanout.sv
// Self-checking bench for video_scanout on a reduced raster (48x23 total,
// 32x16 visible, 8-word framebuffer rows) so whole frames fit in a short run.
// Expected outputs come from the tick index since reset: tick n reads
// raster position n-1 and presents position n-2 at the outputs.
module tb_video_scanout;

    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 16, VF = 2, VS = 2, VB = 3;
    localparam int SC = 4, FBW = 8;
    localparam logic [31:0] BASE = 32'h0000_0A00;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_ce = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rd_data = 32'h0;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;
    int ticks = 0;
    int mode = 0;

    video_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SCALE(SC), .FB_WIDTH(FBW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .enable(enable),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // memory contents: mode 0 returns the address itself, mode 1 a scramble
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [11:0] lo;
        lo = (mode == 0) ? a[11:0] : (a[11:0] ^ a[13:2] ^ 12'h5A3);
        return {~a[19:0], lo};
    endfunction

    function automatic int hpos(input int idx);
        return idx % HT;
    endfunction

    function automatic int vpos(input int idx);
        return (idx / HT) % VT;
    endfunction

    function automatic logic visible(input int idx);
        return (hpos(idx) < HA) && (vpos(idx) < VA);
    endfunction

    function automatic logic [31:0] addr_of(input int idx);
        return BASE + 32'((vpos(idx) / SC) * FBW * 4 + (hpos(idx) / SC) * 4);
    endfunction

    // memory model: data valid one clk after the strobe, junk otherwise
    always @(negedge clk) begin
        rd_data = rd_en ? mem_word(rd_addr) : $urandom();
    end

    // reference model and per-clk comparison
    logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_rd = 1'b0;
    logic [11:0] e_rgb = 12'h0;
    logic        prev_en = 1'b0;
    logic [31:0] word;
    int          n, idx;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            ticks = 0;
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 12'h0;
            e_fs = 1'b0; e_rd = 1'b0;
            chk("reset_rd_addr", rd_addr, 32'h0);
        end else if (pix_ce) begin
            n = ticks + 1;
            e_rd = visible(n - 1) && enable;
            if (e_rd) chk("rd_addr", rd_addr, addr_of(n - 1));
            e_fs = 1'b0;
            if (n >= 2) begin
                idx = n - 2;
                e_de = visible(idx);
                e_hs = !((hpos(idx) >= HA + HF) && (hpos(idx) < HA + HF + HS));
                e_vs = !((vpos(idx) >= VA + VF) && (vpos(idx) < VA + VF + VS));
                word = mem_word(addr_of(idx));
                e_rgb = (e_de && prev_en) ? word[11:0] : 12'h0;
                e_fs = (idx % FRAME == 0);
            end
            prev_en = enable;
            ticks = n;
        end else begin
            e_rd = 1'b0;
            e_fs = 1'b0;
        end
        chk("rd_en", {31'h0, rd_en}, {31'h0, e_rd});
        chk("hsync", {31'h0, hsync}, {31'h0, e_hs});
        chk("vsync", {31'h0, vsync}, {31'h0, e_vs});
        chk("de", {31'h0, de}, {31'h0, e_de});
        chk("rgb", {20'h0, rgb}, {20'h0, e_rgb});
        chk("frame_start", {31'h0, frame_start}, {31'h0, e_fs});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    int hs_lo, de_hi, vs_lo, fs_cnt, rd_cnt, guard, target;

    initial begin
        rst = 1'b0; pix_ce = 1'b1; enable = 1'b1; mode = 0;
        repeat (5) @(negedge clk);
        rst = 1'b1;

        // unthrottled scan from reset: literal pins plus one-frame geometry
        hs_lo = 0; de_hi = 0; vs_lo = 0; fs_cnt = 0;
        for (int k = 1; k <= 1106; k++) begin
            @(posedge clk); #2;
            if (k == 1) begin
                chk("first_rd_en", {31'h0, rd_en}, 32'h1);
                chk("first_rd_addr", rd_addr, BASE);
                chk("first_de", {31'h0, de}, 32'h0);
                chk("first_hsync", {31'h0, hsync}, 32'h1);
            end
            if (k == 2) begin
                chk("de_rise", {31'h0, de}, 32'h1);
                chk("line0_px0", {20'h0, rgb}, 32'hA00);
                chk("frame_start_first", {31'h0, frame_start}, 32'h1);
            end
            if (k == 5)   chk("line0_px3", {20'h0, rgb}, 32'hA00);
            if (k == 6)   chk("line0_px4", {20'h0, rgb}, 32'hA04);
            if (k == 50)  chk("line1_px0", {20'h0, rgb}, 32'hA00);
            if (k == 54)  chk("line1_px4", {20'h0, rgb}, 32'hA04);
            if (k == 194) chk("line4_px0", {20'h0, rgb}, 32'hA20);
            if (k == 752) begin
                chk("last_px_rd_en", {31'h0, rd_en}, 32'h1);
                chk("last_px_addr", rd_addr, BASE + 32'h7C);
            end
            if (k >= 2 && k <= 1105) begin
                if (!hsync) hs_lo++;
                if (de) de_hi++;
                if (!vsync) vs_lo++;
                if (frame_start) fs_cnt++;
            end
            if (k == 1106) chk("frame_period", {31'h0, frame_start}, 32'h1);
        end
        // 6 sync clks x 23 lines, 32 x 16 visible, 2 lines x 48, one pulse
        chk("hsync_low_clks", hs_lo, 138);
        chk("de_high_clks", de_hi, 512);
        chk("vsync_low_clks", vs_lo, 96);
        chk("frame_start_count", fs_cnt, 1);

        // async reset mid-read at line 10, pixel 5 of the second frame
        target = FRAME + 10 * HT + 5;
        guard = 0;
        while (ticks != target && guard < 5000) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("reset_point_reached", ticks, target);
        #1 rst = 1'b0;
        mode = 1;
        #1;
        chk("async_hsync", {31'h0, hsync}, 32'h1);
        chk("async_vsync", {31'h0, vsync}, 32'h1);
        chk("async_de", {31'h0, de}, 32'h0);
        chk("async_rgb", {20'h0, rgb}, 32'h0);
        chk("async_rd_en", {31'h0, rd_en}, 32'h0);
        chk("async_rd_addr", rd_addr, 32'h0);
        chk("async_frame_start", {31'h0, frame_start}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("restart_rd_en", {31'h0, rd_en}, 32'h1);
        chk("restart_rd_addr", rd_addr, BASE);

        // pix_ce every 4th clk
        for (int c = 0; c < 4800; c++) begin
            @(negedge clk);
            pix_ce = (c % 4 == 0) ? 1'b1 : 1'b0;
        end

        // random pix_ce and per-pixel enable
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pix_ce = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0;
        end

        // enable dropped for pixels 10..19 of every line
        pix_ce = 1'b1;
        rd_cnt = 0; de_hi = 0;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            if (c >= 100 && c < 100 + FRAME) begin
                if (rd_en) rd_cnt++;
                if (de) de_hi++;
            end
            enable = ((ticks % HT) >= 10 && (ticks % HT) < 20) ? 1'b0 : 1'b1;
        end
        // (32 - 10 gated pixels) x 16 lines
        chk("gated_read_count", rd_cnt, 352);
        chk("gated_de_count", de_hi, 512);

        @(negedge clk);
        pix_ce = 1'b0;
        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
